branch_predictor: RTL and testbench
===================================

# branch_predictor

Bimodal branch predictor that produces the `pred_taken` hint consumed by the fetch-stage program counter and is trained by branch resolutions returning from the execute stage. It holds a table of 2-bit saturating counters indexed by PC, decodes the fetched instruction to qualify predictions to conditional branches, and flags mispredictions back to the hazard/PC logic. It also keeps branch and mispredict performance counters.

## Interface
Parameters:
- `WIDTH`, 32: PC width.
- `IDX_BITS`, 4: table index width; the table has 2^IDX_BITS entries.
- `CNT_WIDTH`, 32: width of the performance counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: pipeline stall; blocks training and counter updates.
- `PCF`  in  WIDTH: fetch-stage PC used for lookup.
- `InstrF`  in  32: fetched instruction.
- `pred_taken`  out  1: prediction for the instruction at `PCF`; combinational.
- `branchE`  in  1: a conditional branch is resolving in execute this cycle.
- `PCE`  in  WIDTH: PC of the resolving branch.
- `takenE`  in  1: actual branch outcome.
- `pred_takenE`  in  1: prediction that was made for this branch, piped from fetch.
- `mispredictE`  out  1: combinational misprediction flag.
- `branch_count`  out  CNT_WIDTH: resolved branches counted.
- `mispredict_count`  out  CNT_WIDTH: mispredictions counted.

## Operation
- Lookup index: `PCF[IDX_BITS+1:2]`. Update index: `PCE[IDX_BITS+1:2]`. PC bits [1:0] are ignored. Upper bits are ignored, so aliasing between PCs that share index bits is expected behaviour.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. The prediction is counter bit [1].
- `pred_taken = (InstrF[6:0] == 7'b1100011) && table[lookup_idx][1]`. Non-branch opcodes, including JAL and JALR, always give 0.
- Training happens when `branchE && !stall`:
  - If `takenE` is 1, the counter increments, saturating at 11.
  - If `takenE` is 0, the counter decrements, saturating at 00.
  - Only the indexed entry changes.
- `mispredictE = branchE && (takenE != pred_takenE)`. This output is not gated by `stall`.
- Performance counters:
  - When `branchE && !stall`, `branch_count` increments.
  - When `mispredictE && !stall`, `mispredict_count` increments.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Reset, asynchronous:
  - Every table entry is set to 01.
  - `branch_count` and `mispredict_count` are set to 0.
  - `pred_taken` therefore reads 0 for every PC while reset is held and after it is released.
- Lookup latency: 0 cycles, combinational from `PCF`/`InstrF`.
- Training latency: one cycle. The updated counter is visible to lookup in the cycle after the training edge.
- Simultaneous lookup and update of the same index: lookup returns the pre-update value. There is no write-to-read bypass.
- `stall` held high with `branchE` high: no table or counter change, no matter how many cycles it lasts. Exactly one training event occurs, in the first cycle where `stall` is low.
- Reset asserted mid-operation: state clears immediately, without waiting for a clock edge, and overrides any training in that cycle.

## Test plan
- Reset, then `PCF`=0x100 with a BEQ opcode (0x63) → `pred_taken`=0. Apply `InstrF` opcode 0x6F (JAL) → 0.
- Train `PCE`=0x100 with `takenE`=1 once → next cycle, BEQ at 0x100 predicts 1. Train 2 more times taken (counter 11), then once not-taken → still predicts 1. A second not-taken → predicts 0.
- Alias check with IDX_BITS=4: train 0x40 taken once → a branch at 0x80 predicts 1 and a branch at 0x44 predicts 0.
- `branchE`=1, `takenE`=1, `pred_takenE`=0, `stall`=1 for 3 cycles, then `stall`=0 for 1 cycle:
  - `mispredictE`=1 in all 4 cycles.
  - `branch_count`=1 and `mispredict_count`=1 afterwards.
  - The counter advanced exactly one step.
- CNT_WIDTH=4: apply 20 resolved branches → `branch_count` stays at 15.
- Train several entries, then pulse `rst` between clock edges → outputs and counters clear immediately, and all lookups give 0 afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Bimodal 2-bit-counter branch predictor with mispredict flagging
//            and saturating branch / mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int WIDTH     = 32,
   parameter int IDX_BITS  = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [WIDTH-1:0]     PCF,
   input  logic [31:0]          InstrF,
   output logic                 pred_taken,
   input  logic                 branchE,
   input  logic [WIDTH-1:0]     PCE,
   input  logic                 takenE,
   input  logic                 pred_takenE,
   output logic                 mispredictE,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] mispredict_count
);

   localparam int              ENTRIES       = 1 << IDX_BITS;
   localparam logic [6:0]      c_OP_BRANCH   = 7'b1100011;
   localparam logic [1:0]      c_STRONG_NT   = 2'b00;
   localparam logic [1:0]      c_WEAK_NT     = 2'b01;
   localparam logic [1:0]      c_STRONG_T    = 2'b11;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [1:0]           table_q [ENTRIES];
   logic [1:0]           ctr_d;
   logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
   logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

   logic [IDX_BITS-1:0]  w_lookup_idx;
   logic [IDX_BITS-1:0]  w_upd_idx;
   logic [1:0]           w_ctr_cur;
   logic                 w_upd_en;
   logic                 w_is_branch;
   logic                 w_mispredict;
   logic                 w_unused;

   assign w_lookup_idx = PCF[IDX_BITS+1:2];
   assign w_upd_idx    = PCE[IDX_BITS+1:2];
   assign w_is_branch  = (InstrF[6:0] == c_OP_BRANCH);
   assign w_upd_en     = branchE & ~stall;
   assign w_mispredict = branchE & (takenE ^ pred_takenE);
   assign w_ctr_cur    = table_q[w_upd_idx];

   // Lookup reads the registered table, so a same-cycle update is not bypassed.
   assign pred_taken       = w_is_branch & table_q[w_lookup_idx][1];
   assign mispredictE      = w_mispredict;
   assign branch_count     = bcnt_q;
   assign mispredict_count = mcnt_q;

   assign w_unused = ^{PCF[WIDTH-1:IDX_BITS+2], PCF[1:0],
                       PCE[WIDTH-1:IDX_BITS+2], PCE[1:0], InstrF[31:7]};

   always_comb begin
      ctr_d = w_ctr_cur;
      if (takenE) begin
         if (w_ctr_cur != c_STRONG_T) begin
            ctr_d = w_ctr_cur + 2'd1;
         end
      end else begin
         if (w_ctr_cur != c_STRONG_NT) begin
            ctr_d = w_ctr_cur - 2'd1;
         end
      end
   end

   always_comb begin
      bcnt_d = bcnt_q;
      mcnt_d = mcnt_q;
      if (w_upd_en && (bcnt_q != c_CNT_MAX)) begin
         bcnt_d = bcnt_q + c_CNT_ONE;
      end
      if (w_mispredict && !stall && (mcnt_q != c_CNT_MAX)) begin
         mcnt_d = mcnt_q + c_CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= c_WEAK_NT;
         end
      end else if (w_upd_en) begin
         table_q[w_upd_idx] <= ctr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   localparam int WIDTH     = 32;
   localparam int IDX_BITS  = 4;
   localparam int CNT_WIDTH = 4;
   localparam int CNT_MAX   = 15;
   localparam int ENTRIES   = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 stall;
   logic [WIDTH-1:0]     PCF;
   logic [31:0]          InstrF;
   logic                 pred_taken;
   logic                 branchE;
   logic [WIDTH-1:0]     PCE;
   logic                 takenE;
   logic                 pred_takenE;
   logic                 mispredictE;
   logic [CNT_WIDTH-1:0] branch_count;
   logic [CNT_WIDTH-1:0] mispredict_count;

   int checks   = 0;
   int failures = 0;

   // Reference state: counter strength 0..3 per entry, plain integer counts.
   int mdl_ctr [ENTRIES];
   int mdl_bc;
   int mdl_mc;

   branch_predictor #(
      .WIDTH     (WIDTH),
      .IDX_BITS  (IDX_BITS),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .PCF              (PCF),
      .InstrF           (InstrF),
      .pred_taken       (pred_taken),
      .branchE          (branchE),
      .PCE              (PCE),
      .takenE           (takenE),
      .pred_takenE      (pred_takenE),
      .mispredictE      (mispredictE),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   function automatic int entry_of(input logic [WIDTH-1:0] pc);
      return int'(pc / 4) % ENTRIES;
   endfunction

   function automatic logic mdl_pred(input logic [WIDTH-1:0] pc, input logic [31:0] instr);
      return (instr[6:0] == 7'h63) && (mdl_ctr[entry_of(pc)] >= 2);
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < ENTRIES; i++) mdl_ctr[i] = 1;
      mdl_bc = 0;
      mdl_mc = 0;
   endtask

   // Advance one clock edge, updating the model from the inputs presented.
   task automatic step();
      if (branchE && !stall) begin
         if (takenE) mdl_ctr[entry_of(PCE)] = (mdl_ctr[entry_of(PCE)] < 3) ? mdl_ctr[entry_of(PCE)] + 1 : 3;
         else        mdl_ctr[entry_of(PCE)] = (mdl_ctr[entry_of(PCE)] > 0) ? mdl_ctr[entry_of(PCE)] - 1 : 0;
         if (mdl_bc < CNT_MAX) mdl_bc++;
         if ((takenE != pred_takenE) && mdl_mc < CNT_MAX) mdl_mc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mdl_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic train(input logic [WIDTH-1:0] pc, input logic tk);
      branchE = 1'b1; PCE = pc; takenE = tk; pred_takenE = tk; stall = 1'b0;
      step();
      branchE = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; branchE = 1'b0; PCE = '0; takenE = 1'b0;
      pred_takenE = 1'b0; PCF = 32'h100; InstrF = 32'h0000_0063;
      mdl_reset();
      #2;
      checks++;
      if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_held got=%b exp=0", pred_taken); end
      checks++;
      if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
         failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      for (int i = 0; i < ENTRIES; i++) begin
         PCF = 32'(i * 4);
         #1;
         checks++;
         if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred idx=%0d got=%b exp=0", i, pred_taken); end
      end
      PCF = 32'h100; InstrF = 32'h0000_006F;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin failures++; $display("FAIL jal_pred got=%b exp=0", pred_taken); end
   endtask

   task automatic test_training();
      logic [6:0] exp [5];
      logic       tks [5];
      exp = '{1, 1, 1, 1, 0};
      tks = '{1, 1, 1, 0, 0};
      PCF = 32'h100; InstrF = 32'h0000_0063;
      for (int i = 0; i < 5; i++) begin
         train(32'h100, tks[i]);
         checks++;
         if (pred_taken !== exp[i][0] || pred_taken !== mdl_pred(PCF, InstrF)) begin
            failures++; $display("FAIL train_step%0d got=%b exp=%b", i, pred_taken, exp[i][0]);
         end
      end
   endtask

   task automatic test_alias();
      do_reset();
      train(32'h40, 1'b1);
      InstrF = 32'h0000_0063;
      PCF = 32'h80;
      #1;
      checks++;
      if (pred_taken !== 1'b1) begin failures++; $display("FAIL alias_0x80 got=%b exp=1", pred_taken); end
      PCF = 32'h44;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin failures++; $display("FAIL alias_0x44 got=%b exp=0", pred_taken); end
   endtask

   task automatic test_stall();
      do_reset();
      PCF = 32'h200; InstrF = 32'h0000_0063;
      branchE = 1'b1; PCE = 32'h200; takenE = 1'b1; pred_takenE = 1'b0;
      for (int i = 0; i < 4; i++) begin
         stall = (i < 3);
         #1;
         checks++;
         if (mispredictE !== 1'b1) begin failures++; $display("FAIL stall_mispredict cyc=%0d got=%b exp=1", i, mispredictE); end
         step();
      end
      branchE = 1'b0; stall = 1'b0;
      checks++;
      if (branch_count !== 4'd1 || mispredict_count !== 4'd1) begin
         failures++; $display("FAIL stall_counts got=%0d/%0d exp=1/1", branch_count, mispredict_count);
      end
      checks++;
      if (pred_taken !== 1'b1) begin failures++; $display("FAIL stall_pred got=%b exp=1", pred_taken); end
      // One step back from weak-taken must drop the prediction.
      train(32'h200, 1'b0);
      checks++;
      if (pred_taken !== 1'b0) begin failures++; $display("FAIL stall_one_step got=%b exp=0", pred_taken); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         branchE = 1'b1; PCE = 32'(i * 4); takenE = i[0]; pred_takenE = 1'b0; stall = 1'b0;
         step();
      end
      branchE = 1'b0;
      checks++;
      if (branch_count !== 4'd15) begin failures++; $display("FAIL sat_branch got=%0d exp=15", branch_count); end
      checks++;
      if (mispredict_count !== 4'd10) begin failures++; $display("FAIL sat_mispredict got=%0d exp=10", mispredict_count); end
   endtask

   task automatic test_same_index();
      do_reset();
      PCF = 32'h308; InstrF = 32'h0000_0063;
      train(32'h308, 1'b1);
      branchE = 1'b1; PCE = 32'h308; takenE = 1'b0; pred_takenE = 1'b1; stall = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b1) begin failures++; $display("FAIL same_idx_pre got=%b exp=1", pred_taken); end
      step();
      branchE = 1'b0;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_idx_post got=%b exp=0", pred_taken); end
   endtask

   task automatic test_random();
      logic [6:0] ops [4];
      ops = '{7'h63, 7'h6F, 7'h67, 7'h33};
      do_reset();
      for (int n = 0; n < 300; n++) begin
         PCF         = $urandom;
         InstrF      = {$urandom_range(0, 32'h01FF_FFFF), 7'h00} | {25'd0, ops[($urandom_range(0, 5) > 3) ? $urandom_range(1, 3) : 0]};
         branchE     = ($urandom_range(0, 9) < 6);
         PCE         = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 63));
         takenE      = ($urandom_range(0, 3) != 0);
         pred_takenE = $urandom_range(0, 1);
         stall       = ($urandom_range(0, 3) == 0);
         if (n == 150) do_reset();
         #1;
         checks++;
         if (pred_taken !== mdl_pred(PCF, InstrF)) begin
            failures++; $display("FAIL rnd_pred n=%0d pc=%h got=%b exp=%b", n, PCF, pred_taken, mdl_pred(PCF, InstrF));
         end
         checks++;
         if (mispredictE !== (branchE && (takenE != pred_takenE))) begin
            failures++; $display("FAIL rnd_mispredict n=%0d got=%b", n, mispredictE);
         end
         checks++;
         if (int'(branch_count) != mdl_bc || int'(mispredict_count) != mdl_mc) begin
            failures++; $display("FAIL rnd_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, branch_count, mispredict_count, mdl_bc, mdl_mc);
         end
         step();
      end
      branchE = 1'b0; stall = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      train(32'h0, 1'b1);
      train(32'h14, 1'b1);
      train(32'h3C, 1'b1);
      #2;
      rst = 1'b1;
      mdl_reset();
      #1;
      checks++;
      if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
         failures++; $display("FAIL async_counts got=%0d/%0d exp=0/0", branch_count, mispredict_count);
      end
      rst = 1'b0;
      InstrF = 32'h0000_0063;
      for (int i = 0; i < ENTRIES; i++) begin
         PCF = 32'(i * 4);
         #0.1;
         checks++;
         if (pred_taken !== 1'b0) begin failures++; $display("FAIL async_pred idx=%0d got=%b exp=0", i, pred_taken); end
      end
   endtask

   initial begin
      test_reset();
      test_training();
      test_alias();
      test_stall();
      test_saturation();
      test_same_index();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
